// File: rtl/ctrl_decode_pipe_if.sv
// Instruction-side and control-word-side handshake bundle for ctrl_decode_pipe.
// master = the environment (issue stage / downstream), slave = the decode stage.
interface ctrl_decode_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  Op_code;
   logic [5:0]  Funct;
   logic [4:0]  Shamt;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic        out_valid;
   logic        out_ready;
   logic [25:0] Ctrl;
   logic        Exception;

   modport master (
      output in_valid, Op_code, Funct, Shamt, Rs, Rt, out_ready,
      input  in_ready, out_valid, Ctrl, Exception
   );

   modport slave (
      input  in_valid, Op_code, Funct, Shamt, Rs, Rt, out_ready,
      output in_ready, out_valid, Ctrl, Exception
   );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Registered, handshaked MIPS-subset main decoder with multi-cycle busy window and exception log.
// Optional macro MULDIV_EN: makes SPECIAL2 mul (op 011100, funct 000010) legal and multi-cycle.
//
// state | meaning
// IDLE  | accepting instructions; output register holds last decoded word
// BUSY  | multi-cycle op in flight; counter runs down to the output load
module ctrl_decode_pipe #(
   parameter int MUL_LAT   = 4,
   parameter int EXC_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ctrl_decode_pipe_if.slave    bus,
   input  logic                 flush,
   output logic [EXC_CNT_W-1:0] exc_count,
   output logic [11:0]          exc_last
);

   // Field order matches the Ctrl port, MSB first; the three LSBs are reserved zero.
   typedef struct packed {
      logic       ext_op;
      logic       reg_dst;
      logic       shift_amount_src;
      logic       jump;
      logic       alu_shift_sel;
      logic       reg_dt0;
      logic [3:0] alu_op;
      logic [1:0] shift_op;
      logic [2:0] alu_src_b;
      logic [2:0] condition;
      logic [1:0] load_type;
      logic       reg_wr;
      logic       mem_wr;
      logic       mem_to_reg;
      logic [2:0] rsvd;
   } ctrl_t;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam bit MULTI_CYCLE = (MUL_LAT > 1);

   state_t               state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic                 ov_q, ov_nxt;
   ctrl_t                ctrl_q, ctrl_nxt, pend_q, pend_nxt, dec;
   logic                 exc_q, exc_nxt, dec_exc, dec_multi;
   logic [EXC_CNT_W-1:0] exc_count_nxt;
   logic [11:0]          exc_last_nxt;
   logic                 in_ready_c, accept;
   logic                 unused_fields;

   assign unused_fields = ^{bus.Shamt, bus.Rs, bus.Rt};

   always_comb begin
      dec       = '0;
      dec_exc   = 1'b0;
      dec_multi = 1'b0;
      case (bus.Op_code)
         6'b000000: begin
            dec.reg_dst = 1'b1;
            dec.reg_wr  = 1'b1;
            case (bus.Funct)
               6'b100000: dec.alu_op = 4'b1110;
               6'b100010: dec.alu_op = 4'b1111;
               6'b100011: dec.alu_op = 4'b0001;
               6'b101011: dec.alu_op = 4'b0111;
               6'b000111: begin
                  dec.alu_shift_sel    = 1'b1;
                  dec.shift_amount_src = 1'b1;
                  dec.shift_op         = 2'd2;
               end
               6'b000010: begin
                  dec.alu_shift_sel = 1'b1;
                  dec.shift_op      = 2'd3;
               end
               default: begin
                  dec     = '0;
                  dec_exc = 1'b1;
               end
            endcase
         end
         6'b000001: begin
            dec.alu_op    = 4'b0001;
            dec.condition = 3'd3;
            dec.reg_dt0   = 1'b1;
            dec.ext_op    = 1'b1;
            dec.reg_wr    = 1'b1;
         end
         6'b000010: begin
            dec.jump   = 1'b1;
            dec.reg_wr = 1'b1;
         end
         6'b001000, 6'b001001, 6'b001010: begin
            dec.alu_src_b = 3'd1;
            dec.ext_op    = 1'b1;
            dec.reg_wr    = 1'b1;
            if (bus.Op_code == 6'b001000) dec.alu_op = 4'b1110;
            if (bus.Op_code == 6'b001010) dec.alu_op = 4'b0101;
         end
         6'b001110: begin
            dec.alu_src_b = 3'd1;
            dec.alu_op    = 4'b1001;
            dec.reg_wr    = 1'b1;
         end
         6'b001111: begin
            dec.alu_src_b = 3'd4;
            dec.reg_wr    = 1'b1;
         end
         6'b011100: begin
            dec.reg_dst = 1'b1;
            dec.reg_wr  = 1'b1;
            case (bus.Funct)
               6'b100001: dec.alu_op = 4'b0011;
               6'b100000: dec.alu_op = 4'b0010;
`ifdef MULDIV_EN
               6'b000010: begin
                  dec.alu_op = 4'b0100;
                  dec_multi  = 1'b1;
               end
`endif
               default: begin
                  dec     = '0;
                  dec_exc = 1'b1;
               end
            endcase
         end
         6'b011111: begin
            dec.reg_dst = 1'b1;
            dec.reg_wr  = 1'b1;
            dec.alu_op  = 4'b1010;
            dec.ext_op  = 1'b1;
         end
         6'b100011, 6'b100010, 6'b100110: begin
            dec.alu_op     = 4'b1110;
            dec.ext_op     = 1'b1;
            dec.reg_wr     = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.load_type  = (bus.Op_code == 6'b100011) ? 2'b10 :
                             (bus.Op_code == 6'b100010) ? 2'b01 : 2'b11;
         end
         6'b101011: begin
            dec.alu_op = 4'b1110;
            dec.ext_op = 1'b1;
            dec.mem_wr = 1'b1;
         end
         default: dec_exc = 1'b1;
      endcase
   end

   assign in_ready_c = (state == IDLE) & (~ov_q | bus.out_ready) & ~flush;
   assign accept     = bus.in_valid & in_ready_c;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      ov_nxt        = ov_q;
      ctrl_nxt      = ctrl_q;
      exc_nxt       = exc_q;
      pend_nxt      = pend_q;
      exc_count_nxt = exc_count;
      exc_last_nxt  = exc_last;
      if (ov_q & bus.out_ready) ov_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               // Logged at accept so that a later flush cannot hide the event.
               if (dec_exc) begin
                  if (exc_count != '1) exc_count_nxt = exc_count + EXC_CNT_W'(1);
                  exc_last_nxt = {bus.Op_code, bus.Funct};
               end
               if (dec_multi & MULTI_CYCLE) begin
                  state_nxt = BUSY;
                  cnt_nxt   = 4'(MUL_LAT - 1);
                  pend_nxt  = dec;
                  ov_nxt    = 1'b0;
               end else begin
                  ctrl_nxt = dec;
                  exc_nxt  = dec_exc;
                  ov_nxt   = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = IDLE;
               ctrl_nxt  = pend_q;
               exc_nxt   = 1'b0;
               ov_nxt    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = 4'd0;
         ov_nxt    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ov_q      <= 1'b0;
         ctrl_q    <= '0;
         exc_q     <= 1'b0;
         pend_q    <= '0;
         exc_count <= '0;
         exc_last  <= 12'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ov_q      <= ov_nxt;
         ctrl_q    <= ctrl_nxt;
         exc_q     <= exc_nxt;
         pend_q    <= pend_nxt;
         exc_count <= exc_count_nxt;
         exc_last  <= exc_last_nxt;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = ov_q;
   assign bus.Ctrl      = ctrl_q;
   assign bus.Exception = exc_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios plus randomized traffic
// compared every cycle against a table-driven behavioural model.
module tb_ctrl_decode_pipe;
   localparam int MUL_LAT   = 4;
   localparam int EXC_CNT_W = 8;
   localparam int CNT_MAX   = (1 << EXC_CNT_W) - 1;
   localparam logic [25:0] ADD_CTRL = 26'h10E0020;
   localparam logic [25:0] LW_CTRL  = 26'h20E00A8;
   localparam logic [25:0] MUL_CTRL = 26'h1040020;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic [EXC_CNT_W-1:0] exc_count;
   logic [11:0] exc_last;

   ctrl_decode_pipe_if bus ();

   ctrl_decode_pipe #(.MUL_LAT(MUL_LAT), .EXC_CNT_W(EXC_CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .flush(flush),
      .exc_count(exc_count), .exc_last(exc_last)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode: one row per table entry, then pack fields MSB first.
   function automatic void m_decode(input logic [5:0] op, input logic [5:0] fn,
                                    output logic [25:0] c, output bit ill, output bit mul);
      bit e, rd, sas, j, ss, r0, wr, mw, mr;
      logic [3:0] alu; logic [1:0] sh, lt; logic [2:0] sb, cnd;
      {e, rd, sas, j, ss, r0, wr, mw, mr} = '0;
      alu = 0; sh = 0; lt = 0; sb = 0; cnd = 0; ill = 0; mul = 0;
      if      (op == 6'o00 && fn == 6'b100000) begin rd = 1; wr = 1; alu = 4'b1110; end
      else if (op == 6'o00 && fn == 6'b100010) begin rd = 1; wr = 1; alu = 4'b1111; end
      else if (op == 6'o00 && fn == 6'b100011) begin rd = 1; wr = 1; alu = 4'b0001; end
      else if (op == 6'o00 && fn == 6'b101011) begin rd = 1; wr = 1; alu = 4'b0111; end
      else if (op == 6'o00 && fn == 6'b000111) begin rd = 1; wr = 1; ss = 1; sas = 1; sh = 2; end
      else if (op == 6'o00 && fn == 6'b000010) begin rd = 1; wr = 1; ss = 1; sh = 3; end
      else if (op == 6'b000001) begin alu = 4'b0001; cnd = 3; r0 = 1; e = 1; wr = 1; end
      else if (op == 6'b000010) begin j = 1; wr = 1; end
      else if (op == 6'b001000) begin sb = 1; alu = 4'b1110; e = 1; wr = 1; end
      else if (op == 6'b001001) begin sb = 1; e = 1; wr = 1; end
      else if (op == 6'b001010) begin sb = 1; alu = 4'b0101; e = 1; wr = 1; end
      else if (op == 6'b001110) begin sb = 1; alu = 4'b1001; wr = 1; end
      else if (op == 6'b001111) begin sb = 4; wr = 1; end
      else if (op == 6'b011100 && fn == 6'b100001) begin rd = 1; wr = 1; alu = 4'b0011; end
      else if (op == 6'b011100 && fn == 6'b100000) begin rd = 1; wr = 1; alu = 4'b0010; end
`ifdef MULDIV_EN
      else if (op == 6'b011100 && fn == 6'b000010) begin rd = 1; wr = 1; alu = 4'b0100; mul = 1; end
`endif
      else if (op == 6'b011111) begin rd = 1; wr = 1; alu = 4'b1010; e = 1; end
      else if (op == 6'b100011) begin alu = 4'b1110; e = 1; lt = 2'b10; wr = 1; mr = 1; end
      else if (op == 6'b100010) begin alu = 4'b1110; e = 1; lt = 2'b01; wr = 1; mr = 1; end
      else if (op == 6'b100110) begin alu = 4'b1110; e = 1; lt = 2'b11; wr = 1; mr = 1; end
      else if (op == 6'b101011) begin alu = 4'b1110; e = 1; mw = 1; end
      else ill = 1;
      c = {e, rd, sas, j, ss, r0, alu, sh, sb, cnd, lt, wr, mw, mr, 3'b000};
   endfunction

   // Model state: what the stage is presenting, and how many cycles remain until a busy op lands.
   bit          m_ov = 0, m_exc = 0;
   logic [25:0] m_ctrl = '0;
   int          m_cnt = 0, m_busy = 0;
   logic [11:0] m_last = '0;

   function automatic bit m_in_ready();
      return (m_busy == 0) && (!m_ov || bus.out_ready) && !flush;
   endfunction

   always @(posedge clk) begin
      logic [25:0] dc;
      bit ill, mul, acc;
      acc = bus.in_valid && m_in_ready();
      m_decode(bus.Op_code, bus.Funct, dc, ill, mul);
      if (rst) begin
         m_ov = 0; m_ctrl = '0; m_exc = 0; m_cnt = 0; m_last = '0; m_busy = 0;
      end else if (flush) begin
         m_ov = 0; m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin m_ov = 1; m_ctrl = MUL_CTRL; m_exc = 0; end
      end else begin
         if (m_ov && bus.out_ready) m_ov = 0;
         if (acc) begin
            if (ill) begin
               m_cnt  = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
               m_last = {bus.Op_code, bus.Funct};
            end
            if (mul && MUL_LAT > 1) m_busy = MUL_LAT - 1;
            else begin m_ctrl = dc; m_exc = ill; m_ov = 1; end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
         chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("Ctrl", 32'(bus.Ctrl), 32'(m_ctrl));
            chk("Exception", 32'(bus.Exception), 32'(m_exc));
         end
         chk("exc_count", 32'(exc_count), 32'(m_cnt));
         chk("exc_last", 32'(exc_last), 32'(m_last));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic v, input logic ordy);
      bus.Op_code   = op;
      bus.Funct     = fn;
      bus.in_valid  = v;
      bus.out_ready = ordy;
      bus.Shamt     = 5'($urandom);
      bus.Rs        = 5'($urandom);
      bus.Rt        = 5'($urandom);
   endtask

   logic [11:0] pool [0:20] = '{
      12'h020, 12'h022, 12'h023, 12'h02B, 12'h007, 12'h002, 12'h040, 12'h080,
      12'h200, 12'h240, 12'h280, 12'h380, 12'h3C0, 12'h721, 12'h720, 12'h722,
      12'h7C5, 12'h8C0, 12'h880, 12'h980, 12'hAC0
   };

   initial begin
      logic [11:0] pick;
      issue(6'd0, 6'd0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      chk_en = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ctrl", 32'(bus.Ctrl), 32'd0);
      chk("rst_exc_count", 32'(exc_count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // add, 1-cycle latency
      cyc(); issue(6'b000000, 6'b100000, 1'b1, 1'b1);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_ctrl", 32'(bus.Ctrl), 32'(ADD_CTRL));
      chk("add_exc", 32'(bus.Exception), 32'd0);
      cyc();

      // lw stalled for 3 cycles, then drained while the next op is accepted
      issue(6'b100011, 6'd0, 1'b1, 1'b0);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("lw_hold_ctrl", 32'(bus.Ctrl), 32'(LW_CTRL));
         chk("lw_hold_in_ready", 32'(bus.in_ready), 32'd0);
         cyc();
      end
      issue(6'b000000, 6'b100000, 1'b1, 1'b1);
      @(negedge clk);
      chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("drain_next_ctrl", 32'(bus.Ctrl), 32'(ADD_CTRL));
      cyc();

      // saturating exception counter
      for (int i = 0; i < 300; i++) begin
         issue(6'b111111, 6'(i), 1'b1, 1'b1);
         cyc();
      end
      issue(6'd0, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("sat_count", 32'(exc_count), 32'(CNT_MAX));
      chk("sat_last", 32'(exc_last), 32'h0FEB);
      chk("sat_exc", 32'(bus.Exception), 32'd1);
      cyc();

`ifdef MULDIV_EN
      issue(6'b011100, 6'b000010, 1'b1, 1'b1);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b1);
      for (int k = 1; k < MUL_LAT; k++) begin
         @(negedge clk);
         chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
         chk("mul_busy_valid", 32'(bus.out_valid), 32'd0);
         cyc();
      end
      @(negedge clk);
      chk("mul_valid", 32'(bus.out_valid), 32'd1);
      chk("mul_ctrl", 32'(bus.Ctrl), 32'(MUL_CTRL));
      cyc();
      // flush in the second busy cycle
      issue(6'b011100, 6'b000010, 1'b1, 1'b1);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b1);
      cyc(); flush = 1'b1;
      cyc(); flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      for (int k = 0; k < MUL_LAT; k++) begin
         cyc();
         @(negedge clk);
         chk("flush_no_emit", 32'(bus.out_valid), 32'd0);
      end
      cyc();
`else
      issue(6'b011100, 6'b000010, 1'b1, 1'b1);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("mul_illegal_exc", 32'(bus.Exception), 32'd1);
      chk("mul_illegal_ctrl", 32'(bus.Ctrl), 32'd0);
      chk("mul_illegal_last", 32'(exc_last), 32'h0702);
      cyc();
      // flush a stalled output
      issue(6'b100011, 6'd0, 1'b1, 1'b0);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b0); flush = 1'b1;
      cyc(); flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
`endif

      // reset while a stalled output is held
      issue(6'b100011, 6'd0, 1'b1, 1'b0);
      cyc(); issue(6'd0, 6'd0, 1'b0, 1'b0); rst = 1'b1;
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("rst2_valid", 32'(bus.out_valid), 32'd0);
      chk("rst2_ctrl", 32'(bus.Ctrl), 32'd0);
      chk("rst2_exc", 32'(bus.Exception), 32'd0);
      chk("rst2_count", 32'(exc_count), 32'd0);
      chk("rst2_last", 32'(exc_last), 32'd0);
      cyc();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) < 7) pick = pool[$urandom_range(0, 20)];
         else pick = 12'($urandom);
         issue(pick[11:6], pick[5:0], 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6));
         flush = ($urandom_range(0, 19) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         cyc();
      end
      flush = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
